// File: rtl/alu_cc_unit_if.sv
// ----------------------------------------------------------------------------
// alu_cc_unit_if
// Purpose : Bundles the request/response handshake, operands, result and
//           condition-code signals of alu_cc_unit into one interface.
// Signals : in_valid/in_ready  request handshake (accepted when both high)
//           opcode, a, b        operation select and operands
//           set_cc              update condition codes with this op's flags
//           out_valid, result   one-cycle completion pulse and held result
//           cc                  condition codes {Z,N,C,V}
//           cc_wr, cc_din       external condition-code load
// Modports: master drives requests (register-file side / bench),
//           slave is the ALU itself.
// ----------------------------------------------------------------------------
interface alu_cc_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             set_cc;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [3:0]       cc;
    logic             cc_wr;
    logic [3:0]       cc_din;

    modport master (
        output in_valid, opcode, a, b, set_cc, cc_wr, cc_din,
        input  in_ready, out_valid, result, cc
    );

    modport slave (
        input  in_valid, opcode, a, b, set_cc, cc_wr, cc_din,
        output in_ready, out_valid, result, cc
    );
endinterface

// File: rtl/alu_cc_unit.sv
// ----------------------------------------------------------------------------
// alu_cc_unit
// Purpose : Integer ALU with a built-in condition-code register {Z,N,C,V}
//           and a one-bit-per-cycle shifter. One operation is accepted per
//           handshake; the result is registered and announced by a one-cycle
//           out_valid pulse.
// Ports   : Clk  - clock, all state changes on the rising edge
//           Clr  - synchronous active-high reset, overrides everything
//           bus  - alu_cc_unit_if.slave (handshake, operands, result, cc)
// Latency : 1 cycle for non-shift ops and shifts by 0, n+1 cycles for a
//           shift by n >= 1.
// ----------------------------------------------------------------------------
module alu_cc_unit #(
    parameter int WIDTH = 32
) (
    input  logic         Clk,
    input  logic         Clr,
    alu_cc_unit_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_ADDX = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SUBX = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_XNOR = 4'b0111,
        OP_ANDN = 4'b1000,
        OP_ORN  = 4'b1001,
        OP_SLL  = 4'b1010,
        OP_SRL  = 4'b1011,
        OP_SRA  = 4'b1100,
        OP_PSA  = 4'b1101,
        OP_PSB  = 4'b1110,
        OP_NOTB = 4'b1111
    } opcode_e;

    state_e               state_q,  state_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [3:0]           cc_q,     cc_d;
    logic [WIDTH-1:0]     work_q,   work_d;
    logic [SHAMT_W-1:0]   shCnt_q,  shCnt_d;
    opcode_e              shOp_q,   shOp_d;
    logic                 setCc_q,  setCc_d;

    opcode_e              reqOp;
    logic                 cinBit;
    logic [WIDTH:0]       addSum;
    logic [WIDTH:0]       subDiff;
    logic [WIDTH-1:0]     aluRes;
    logic                 aluC;
    logic                 aluV;
    logic [3:0]           aluFlags;
    logic                 isShift;
    logic [SHAMT_W-1:0]   shAmt;
    logic [WIDTH-1:0]     workShifted;

    assign reqOp = opcode_e'(bus.opcode);
    assign shAmt = bus.b[SHAMT_W-1:0];

    // The extended ops take their carry from the stored C bit as it stands
    // before this edge, so a simultaneous cc_wr cannot leak into the sum.
    assign cinBit  = ((reqOp == OP_ADDX) || (reqOp == OP_SUBX)) ? cc_q[1] : 1'b0;
    assign addSum  = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cinBit};
    assign subDiff = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cinBit};
    assign isShift = (reqOp == OP_SLL) || (reqOp == OP_SRL) || (reqOp == OP_SRA);

    // Single-cycle datapath used at acceptance. A shift only reaches this
    // path with a zero amount, in which case it simply returns A.
    // The top bit of subDiff is the borrow, since the operands are
    // zero-extended before subtracting.
    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        unique case (reqOp)
            OP_ADD, OP_ADDX: begin
                aluRes = addSum[WIDTH-1:0];
                aluC   = addSum[WIDTH];
                aluV   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                         (addSum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB, OP_SUBX: begin
                aluRes = subDiff[WIDTH-1:0];
                aluC   = subDiff[WIDTH];
                aluV   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                         (subDiff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  aluRes = bus.a & bus.b;
            OP_OR:   aluRes = bus.a | bus.b;
            OP_XOR:  aluRes = bus.a ^ bus.b;
            OP_XNOR: aluRes = ~(bus.a ^ bus.b);
            OP_ANDN: aluRes = bus.a & ~bus.b;
            OP_ORN:  aluRes = bus.a | ~bus.b;
            OP_SLL, OP_SRL, OP_SRA, OP_PSA: aluRes = bus.a;
            OP_PSB:  aluRes = bus.b;
            OP_NOTB: aluRes = ~bus.b;
            default: aluRes = '0;
        endcase
        aluFlags = {(aluRes == '0), aluRes[WIDTH-1], aluC, aluV};
    end

    // One-bit step of the iterative shifter, direction chosen by the
    // opcode latched at acceptance.
    always_comb begin
        unique case (shOp_q)
            OP_SLL:  workShifted = work_q << 1;
            OP_SRL:  workShifted = work_q >> 1;
            default: workShifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    // Next-state and datapath update. Defaults hold every register; the
    // external cc load is applied last so it wins over any ALU flag update.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cc_d     = cc_q;
        work_d   = work_q;
        shCnt_d  = shCnt_q;
        shOp_d   = shOp_q;
        setCc_d  = setCc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (isShift && (shAmt != '0)) begin
                        work_d  = bus.a;
                        shCnt_d = shAmt;
                        shOp_d  = reqOp;
                        setCc_d = bus.set_cc;
                        state_d = SHIFT;
                    end else begin
                        result_d = aluRes;
                        if (bus.set_cc) begin
                            cc_d = aluFlags;
                        end
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d  = workShifted;
                shCnt_d = shCnt_q - SHAMT_W'(1);
                if (shCnt_q == SHAMT_W'(1)) begin
                    result_d = workShifted;
                    if (setCc_q) begin
                        cc_d = {(workShifted == '0), workShifted[WIDTH-1], 2'b00};
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.cc_wr) begin
            cc_d = bus.cc_din;
        end
    end

    // State register; Clr drops any in-flight operation without completing.
    always_ff @(posedge Clk) begin
        if (Clr) begin
            state_q  <= IDLE;
            result_q <= '0;
            cc_q     <= 4'b0000;
            work_q   <= '0;
            shCnt_q  <= '0;
            shOp_q   <= OP_SLL;
            setCc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cc_q     <= cc_d;
            work_q   <= work_d;
            shCnt_q  <= shCnt_d;
            shOp_q   <= shOp_d;
            setCc_q  <= setCc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cc        = cc_q;

endmodule

// File: doc/alu_cc_unit.md
Name: alu_cc_unit

Overview:
Parametrised-width integer ALU with a built-in condition-code register (Z N C V) and a multi-cycle barrel-free shifter.
- Sits between the register-file read stage and writeback.
- Accepts one operation per handshake and returns a registered result.
- Optionally updates the condition codes. ADDX/SUBX take the carry-in from the stored C bit rather than from a port.
- Replaces the combinational ALU plus separate 4-bit flag register pair.

Parameters:
WIDTH, 32, datapath width in bits; power of two, minimum 8.
SHAMT_W, $clog2(WIDTH), derived localparam (not overridable): shift-amount field width.

Ports:
Clk  input  1  clock, all state updates on rising edge
Clr  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  high only in IDLE; request accepted on edge where in_valid & in_ready
opcode  input  4  operation select, sampled at acceptance
a  input  WIDTH  operand A, sampled at acceptance
b  input  WIDTH  operand B, sampled at acceptance; shifts use b[SHAMT_W-1:0] only
set_cc  input  1  update cc with this operation's flags, sampled at acceptance
out_valid  output  1  one-cycle pulse, result valid
result  output  WIDTH  registered result, held until next completion or Clr
cc  output  4  condition codes {Z,N,C,V}
cc_wr  input  1  external cc load enable
cc_din  input  4  external cc value

Behaviour:
- Reset (Clr=1 at edge): state=IDLE, result=0, cc=4'b0000, out_valid=0. Clr overrides every other input. An in-flight op is dropped with no completion.
- FSM states: IDLE, SHIFT, DONE. in_ready=1 in IDLE only; in_valid outside IDLE is ignored.
- IDLE, accept, non-shift op, or shift with amount 0: compute, load result/flags, go to DONE.
- IDLE, accept, shift with amount n>=1: load A into work reg, counter=n, go to SHIFT.
- SHIFT: shift work reg 1 bit per edge and decrement the counter. On the edge where counter==1, write the final value to result and go to DONE.
- DONE: out_valid=1 for exactly one cycle, then IDLE.
- Latency: out_valid is high in the cycle after acceptance for non-shift ops (latency 1). For shifts by n>=1, latency is n+1. Next acceptance is possible at the earliest 2 cycles after the previous one.
- Opcodes:
  - 0000 ADD a+b; 0001 ADDX a+b+C; 0010 SUB a-b; 0011 SUBX a-b-C.
  - 0100 AND; 0101 OR; 0110 XOR; 0111 XNOR; 1000 ANDN a&~b; 1001 ORN a|~b.
  - 1010 SLL; 1011 SRL (zero fill); 1100 SRA (sign fill).
  - 1101 pass a; 1110 pass b; 1111 ~b.
  - All logic ops are bitwise (not logical).
- C for ADDX/SUBX is cc[1] as registered at the acceptance edge. A cc_wr on that same edge does not affect it.
- Flags:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD/ADDX: C = carry out of bit WIDTH-1; V = signed overflow, i.e. (a[msb]==b'[msb]) & (result[msb]!=a[msb]), where b' is the effective addend.
  - SUB/SUBX: C = borrow (1 when a < b+cin unsigned); V = (a[msb]!=b[msb]) & (result[msb]!=a[msb]).
  - All other ops: C=0, V=0.
- cc update: flags are written on the edge entering DONE, only if the latched set_cc=1.
- cc_wr=1 loads cc_din on any edge. If it coincides with an ALU cc update, cc_din wins.
- All arithmetic is modulo 2^WIDTH; no output is wider than WIDTH.

Test Plan:
1. WIDTH=32, ADD 0x7FFFFFFF+0x00000001, set_cc=1 -> next cycle: out_valid=1, result=0x80000000, cc=0101; out_valid=0 the following cycle.
2. SUB 5-5 set_cc=1 -> result=0, cc=1000. Then SUB 3-5 -> result=0xFFFFFFFE, cc=0110.
3. cc_wr=1, cc_din=0010. Then ADDX 0xFFFFFFFF+0, set_cc=1 -> result=0x00000000, cc=1010. Then SUBX 0-0 with C=1 -> result=0xFFFFFFFF, cc=0110.
4. SRA 0x80000000 by b=0x24 (amount 4) -> in_ready low for 5 cycles; in_valid pulses meanwhile are ignored; out_valid 5 cycles after acceptance, result=0xF8000000. SLL by 0 -> latency 1, result=a.
5. AND 0xF0F0F0F0 & 0x0FF00FF0, set_cc=0 with cc=1010 -> result=0x00F000F0, cc stays 1010. XOR with set_cc=1 plus cc_wr=1, cc_din=0001 on the DONE edge -> cc=0001.
6. Clr asserted mid-SHIFT -> next cycle: in_ready=1, out_valid=0, result=0, cc=0000, no late out_valid. WIDTH=16: SLL 0x0001 by 15 -> 0x8000 after 16 cycles, cc=0100 when set_cc=1.
